// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller.
// The MDU FSM encodings and the x0 register index are kept here so that
// the top and the source-match sub-module use the same values.
package hazard_ctrl_pkg;

  // Width of the MDU latency down-counter
  localparam int unsigned CNT_W = 5;

  // MDU FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  // Hard-wired zero register
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_src_match.sv
// src_match: checks whether either source operand of the ID instruction
// reads a candidate destination register. x0 never matches, because
// writes to x0 are discarded and cannot create a dependency.
//   rs1, rs2         ID source registers
//   use_rs1, use_rs2 the ID instruction actually reads that source
//   rd               candidate producer destination
//   hit              some used source equals rd, and rd is not x0
module src_match
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rd,
  output logic       hit
);

  assign hit = (rd != REG_X0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage RV32 pipeline.
// It resolves load-use hazards, branch redirects and hazards against a
// fixed-latency MDU that writes back out of order. It tracks the MDU's
// pending destination and takes the register-file write port for the
// MDU write-back cycle by freezing the whole pipeline.
//   clk, rstn                  core clock, async active-low reset
//   id_rs1/id_rs2/id_use_rs*   ID-stage sources and their use flags
//   id_rd/id_RegWrite          ID-stage destination and write enable
//   id_is_mdu                  ID instruction is an MDU operation
//   IDEX_MemRead/IDEX_rd       EX-stage load flag and destination
//   ex_mdu_issue               EX-stage MDU operation issuing
//   ex_br_taken                EX-stage PC redirect
//   stall_pc/stall_ifid        hold PC and IF/ID
//   flush_ifid/flush_idex      squash IF/ID, insert ID/EX bubble
//   freeze                     hold every pipeline register this cycle
//   mdu_busy/mdu_wb/mdu_rd     MDU status, write-back strobe, destination
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_RegWrite,
  input  logic       id_is_mdu,
  input  logic       IDEX_MemRead,
  input  logic [4:0] IDEX_rd,
  input  logic       ex_mdu_issue,
  input  logic       ex_br_taken,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       freeze,
  output logic       mdu_busy,
  output logic       mdu_wb,
  output logic [4:0] mdu_rd
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic lu_src_hit;
  logic mdu_src_hit;
  logic pend;
  logic mdu_hit;
  logic mdu_struct;
  logic lu_hit;
  logic hold;

  // Counter holds BUSY cycles remaining minus one, so BUSY spans
  // MDU_LAT-1 cycles and WB lands exactly MDU_LAT cycles after issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mdu_rd <= REG_X0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_mdu_issue && !freeze) begin
            state  <= S_BUSY;
            cnt    <= CNT_W'(MDU_LAT - 2);
            mdu_rd <= IDEX_rd;
          end
        end
        S_BUSY: begin
          if (cnt == '0) state <= S_WB;
          else           cnt   <= cnt - 1'b1;
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mdu_busy = (state != S_IDLE);
  assign mdu_wb   = (state == S_WB) && (mdu_rd != REG_X0);
  assign freeze   = mdu_wb;

  src_match u_lu_match (
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .use_rs1 (id_use_rs1),
    .use_rs2 (id_use_rs2),
    .rd      (IDEX_rd),
    .hit     (lu_src_hit)
  );

  src_match u_mdu_match (
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .use_rs1 (id_use_rs1),
    .use_rs2 (id_use_rs2),
    .rd      (mdu_rd),
    .hit     (mdu_src_hit)
  );

  assign pend       = mdu_busy && (mdu_rd != REG_X0);
  // WAW is included so a younger write cannot be overtaken by the MDU result
  assign mdu_hit    = pend && (mdu_src_hit || (id_RegWrite && (id_rd == mdu_rd)));
  assign mdu_struct = id_is_mdu && mdu_busy;
  assign lu_hit     = IDEX_MemRead && lu_src_hit;
  assign hold       = lu_hit || mdu_hit || mdu_struct;

  // Freeze outranks a redirect: the branch stays in EX and reasserts next cycle.
  always_comb begin
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (freeze) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
    end else if (ex_br_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (hold) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model that tracks the MDU as "cycles since issue".
module tb_hazard_ctrl;

  localparam int LAT = 8;

  logic       clk;
  logic       rstn;
  logic [4:0] id_rs1, id_rs2, id_rd, IDEX_rd;
  logic       id_use_rs1, id_use_rs2, id_RegWrite, id_is_mdu;
  logic       IDEX_MemRead, ex_mdu_issue, ex_br_taken;
  logic       stall_pc, stall_ifid, flush_ifid, flush_idex, freeze;
  logic       mdu_busy, mdu_wb;
  logic [4:0] mdu_rd;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MDU_LAT(LAT)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_RegWrite  (id_RegWrite),
    .id_is_mdu    (id_is_mdu),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_rd      (IDEX_rd),
    .ex_mdu_issue (ex_mdu_issue),
    .ex_br_taken  (ex_br_taken),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .freeze       (freeze),
    .mdu_busy     (mdu_busy),
    .mdu_wb       (mdu_wb),
    .mdu_rd       (mdu_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: m_age = 0 when no MDU op, else cycles elapsed since issue (1..LAT).
  int         m_age;
  logic [4:0] m_rd;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_age <= 0;
      m_rd  <= 5'd0;
    end else if (m_age == 0) begin
      if (ex_mdu_issue) begin
        m_age <= 1;
        m_rd  <= IDEX_rd;
      end
    end else if (m_age == LAT) begin
      m_age <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // {stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, mdu_busy, mdu_wb, mdu_rd}
  function automatic logic [11:0] model_out();
    logic busy, wb, raw, strct, lu, hz;
    logic sp, fi, fe;
    busy  = (m_age != 0);
    wb    = (m_age == LAT) && (m_rd != 5'd0);
    raw   = busy && (m_rd != 5'd0) &&
            ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd) ||
             (id_RegWrite && id_rd == m_rd));
    strct = id_is_mdu && busy;
    lu    = IDEX_MemRead && (IDEX_rd != 5'd0) &&
            ((id_use_rs1 && id_rs1 == IDEX_rd) || (id_use_rs2 && id_rs2 == IDEX_rd));
    hz    = raw || strct || lu;
    sp = 1'b0; fi = 1'b0; fe = 1'b0;
    if (wb)               sp = 1'b1;
    else if (ex_br_taken) begin fi = 1'b1; fe = 1'b1; end
    else if (hz)          begin sp = 1'b1; fe = 1'b1; end
    return {sp, sp, fi, fe, wb, busy, wb, m_rd};
  endfunction

  always @(negedge clk) begin
    logic [11:0] exp_v, act_v;
    exp_v = model_out();
    act_v = {stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, mdu_busy, mdu_wb, mdu_rd};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t actual=%b required=%b", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp_v);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; IDEX_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_RegWrite = 1'b0; id_is_mdu = 1'b0;
    IDEX_MemRead = 1'b0; ex_mdu_issue = 1'b0; ex_br_taken = 1'b0;
  endtask

  // kind 0: RAW on rs1, 1: structural, 2: WAW
  task automatic run_mdu(input int kind, input logic [4:0] rd);
    next(); clear_in();
    ex_mdu_issue = 1'b1; IDEX_rd = rd;
    #2 chk("mdu_issue_no_stall", {7'd0, stall_pc}, 8'd0);
    next(); clear_in();
    case (kind)
      0: begin id_rs1 = rd; id_use_rs1 = 1'b1; end
      1: id_is_mdu = 1'b1;
      default: begin id_rd = rd; id_RegWrite = 1'b1; end
    endcase
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) next();
      #2;
      chk("mdu_stall",  {7'd0, stall_pc},   8'd1);
      chk("mdu_ifid",   {7'd0, stall_ifid}, 8'd1);
      chk("mdu_wb",     {7'd0, mdu_wb},     (k == 8) ? 8'd1 : 8'd0);
      chk("mdu_freeze", {7'd0, freeze},     (k == 8) ? 8'd1 : 8'd0);
      chk("mdu_bubble", {7'd0, flush_idex}, (k == 8) ? 8'd0 : 8'd1);
      chk("mdu_rd",     {3'd0, mdu_rd},     {3'd0, rd});
    end
    next(); #2;
    chk("mdu_release", {7'd0, stall_pc}, 8'd0);
    chk("mdu_idle",    {7'd0, mdu_busy}, 8'd0);
    clear_in();
  endtask

  initial begin
    clear_in();
    rstn = 1'b0;
    #12;
    chk("reset_outputs", {stall_pc, stall_ifid, flush_ifid, flush_idex,
                          freeze, mdu_busy, mdu_wb, 1'b0}, 8'd0);
    chk("reset_mdu_rd", {3'd0, mdu_rd}, 8'd0);
    next(); rstn = 1'b1;
    next(); #2;
    chk("idle_outputs", {stall_pc, stall_ifid, flush_ifid, flush_idex,
                         freeze, mdu_busy, mdu_wb, 1'b0}, 8'd0);

    // Load-use: one stall cycle, then the load has moved on (bubble in EX)
    next(); IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #2;
    chk("lu_stall_pc",   {7'd0, stall_pc},   8'd1);
    chk("lu_stall_ifid", {7'd0, stall_ifid}, 8'd1);
    chk("lu_flush_idex", {7'd0, flush_idex}, 8'd1);
    chk("lu_flush_ifid", {7'd0, flush_ifid}, 8'd0);
    next(); IDEX_MemRead = 1'b0; IDEX_rd = 5'd0;
    #2 chk("lu_one_cycle", {7'd0, stall_pc}, 8'd0);
    next(); IDEX_MemRead = 1'b1; IDEX_rd = 5'd0; id_rs2 = 5'd0;
    #2 chk("lu_x0_no_stall", {7'd0, stall_pc}, 8'd0);

    // Branch during load-use: flushes only
    next(); IDEX_MemRead = 1'b1; IDEX_rd = 5'd6; id_rs1 = 5'd6; id_use_rs1 = 1'b1;
    ex_br_taken = 1'b1; id_use_rs2 = 1'b0;
    #2;
    chk("br_lu_flushes", {6'd0, flush_ifid, flush_idex}, 8'd3);
    chk("br_lu_nostall", {6'd0, stall_pc, stall_ifid},   8'd0);
    next(); clear_in();

    run_mdu(0, 5'd7);
    run_mdu(1, 5'd3);
    run_mdu(2, 5'd3);

    // Branch in the WB cycle: freeze first, flush next cycle
    next(); ex_mdu_issue = 1'b1; IDEX_rd = 5'd9;
    next(); clear_in();
    repeat (7) next();
    ex_br_taken = 1'b1;
    #2;
    chk("br_wb_freeze",  {7'd0, freeze},                 8'd1);
    chk("br_wb_noflush", {6'd0, flush_ifid, flush_idex}, 8'd0);
    next(); #2;
    chk("br_after_wb_flush", {6'd0, flush_ifid, flush_idex}, 8'd3);
    chk("br_after_wb_nostall", {7'd0, stall_pc}, 8'd0);
    clear_in();

    // rd = x0: busy 8 cycles, no write-back, structural stall still applies
    next(); ex_mdu_issue = 1'b1; IDEX_rd = 5'd0;
    next(); clear_in(); id_use_rs1 = 1'b1; id_RegWrite = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) next();
      #2;
      chk("x0_busy",    {7'd0, mdu_busy}, 8'd1);
      chk("x0_no_wb",   {7'd0, mdu_wb},   8'd0);
      chk("x0_nostall", {7'd0, stall_pc}, 8'd0);
    end
    next(); #2 chk("x0_done", {7'd0, mdu_busy}, 8'd0);
    next(); ex_mdu_issue = 1'b1; IDEX_rd = 5'd0;
    next(); clear_in(); id_is_mdu = 1'b1;
    #2 chk("x0_struct", {7'd0, stall_pc}, 8'd1);
    repeat (8) next();
    clear_in();

    // Async reset mid-operation
    next(); ex_mdu_issue = 1'b1; IDEX_rd = 5'd4;
    next(); clear_in();
    repeat (3) next();
    #2 chk("rst_pre_busy", {7'd0, mdu_busy}, 8'd1);
    rstn = 1'b0;
    #1;
    chk("rst_busy_drop", {7'd0, mdu_busy}, 8'd0);
    chk("rst_rd_drop",   {3'd0, mdu_rd},   8'd0);
    next(); rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      next(); #2 chk("rst_no_wb", {7'd0, mdu_wb}, 8'd0);
    end

    // Randomized traffic, checked every cycle by the model compare process
    for (int n = 0; n < 3000; n++) begin
      next();
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      IDEX_rd      = 5'($urandom_range(0, 7));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      id_RegWrite  = 1'($urandom_range(0, 1));
      id_is_mdu    = ($urandom_range(0, 4) == 0);
      IDEX_MemRead = ($urandom_range(0, 2) == 0);
      ex_mdu_issue = ($urandom_range(0, 5) == 0);
      ex_br_taken  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rstn = 1'b0;
        next(); rstn = 1'b1;
      end
    end

    next(); clear_in();
    repeat (2) next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
